// File: rtl/jts16b_ramrsp.sv
// CPU-side responder for work/video RAM: turns each cs rising edge into one SDRAM
// transaction and returns dout/ok; a one-word read cache short-circuits repeated reads.
module jts16b_ramrsp #(
  parameter int AW       = 17,
  parameter int OFFSET   = 0,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          rnw,
  input  logic [1:0]    dsn,
  input  logic [15:0]   din,
  output logic [15:0]   dout,
  output logic          ok,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_we,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_wrmask,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_data,
  input  logic          sdram_rdy
);

  // Handshake: sdram_req is a level held from request start until the cycle
  // sdram_ack is sampled high; sdram_* payload is stable for that whole time.
  // sdram_dst and sdram_rdy are single-cycle pulses after the ack.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [AW-1:0] OFFSET_W = AW'(OFFSET);

  state_t        state_q, state_d;
  logic          cs_l_q, cs_l_d;
  logic          pending_q, pending_d;
  logic [15:0]   dout_q, dout_d;
  logic          ok_q, ok_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic [15:0]   sdin_q, sdin_d;
  logic [1:0]    wrmask_q, wrmask_d;
  logic [AW-1:0] laddr_q, laddr_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [15:0]   cache_q, cache_d;
  logic          valid_q, valid_d;

  logic rise;
  logic hit;
  logic txn_end;

  always_comb begin
    state_d   = state_q;
    cs_l_d    = cs;
    dout_d    = dout_q;
    ok_d      = ok_q;
    req_d     = req_q;
    we_d      = we_q;
    saddr_d   = saddr_q;
    sdin_d    = sdin_q;
    wrmask_d  = wrmask_q;
    laddr_d   = laddr_q;
    tag_d     = tag_q;
    cache_d   = cache_q;
    valid_d   = valid_q;

    rise      = cs & ~cs_l_q;
    pending_d = cs ? (pending_q | rise) : 1'b0;
    hit       = CACHE_EN && valid_q && (tag_q == addr);
    // An ack arriving together with rdy is handled as if WAIT had been entered.
    txn_end   = (state_q == WAIT) || ((state_q == REQ) && sdram_ack);

    case (state_q)
      IDLE: begin
        if (cs && (pending_q || rise)) begin
          pending_d = 1'b0;
          if (rnw && hit) begin
            dout_d  = cache_q;
            ok_d    = 1'b1;
            state_d = DONE;
          end else if (!rnw && dsn == 2'b11) begin
            ok_d    = 1'b1;
            state_d = DONE;
          end else begin
            saddr_d  = addr + OFFSET_W;
            sdin_d   = din;
            wrmask_d = rnw ? 2'b11 : dsn;
            we_d     = ~rnw;
            laddr_d  = addr;
            req_d    = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: ;
      DONE: begin
        if (!cs) begin
          ok_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (txn_end) begin
      if (!we_q && sdram_dst) begin
        dout_d = sdram_data;
        if (CACHE_EN) begin
          cache_d = sdram_data;
          tag_d   = laddr_q;
          valid_d = 1'b1;
        end
      end
      if (sdram_rdy) begin
        // Writes keep the cached word coherent, even when cs was dropped early.
        if (we_q && CACHE_EN && tag_q == laddr_q) begin
          cache_d[15:8] = wrmask_q[1] ? cache_q[15:8] : sdin_q[15:8];
          cache_d[7:0]  = wrmask_q[0] ? cache_q[7:0]  : sdin_q[7:0];
        end
        if (cs) begin
          ok_d    = 1'b1;
          state_d = DONE;
        end else begin
          ok_d    = 1'b0;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cs_l_q    <= 1'b0;
      pending_q <= 1'b0;
      dout_q    <= '0;
      ok_q      <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      saddr_q   <= '0;
      sdin_q    <= '0;
      wrmask_q  <= 2'b11;
      laddr_q   <= '0;
      tag_q     <= '0;
      cache_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_l_q    <= cs_l_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      ok_q      <= ok_d;
      req_q     <= req_d;
      we_q      <= we_d;
      saddr_q   <= saddr_d;
      sdin_q    <= sdin_d;
      wrmask_q  <= wrmask_d;
      laddr_q   <= laddr_d;
      tag_q     <= tag_d;
      cache_q   <= cache_d;
      valid_q   <= valid_d;
    end
  end

  assign dout         = dout_q;
  assign ok           = ok_q;
  assign sdram_req    = req_q;
  assign sdram_we     = we_q;
  assign sdram_addr   = saddr_q;
  assign sdram_din    = sdin_q;
  assign sdram_wrmask = wrmask_q;

endmodule

// File: tb/tb_jts16b_ramrsp.sv
// Bench for jts16b_ramrsp: instance A (OFFSET=0, cache on) carries most tests,
// instance B (OFFSET=0x1FFFF, cache off) covers address wrap and the uncached path.
module tb_jts16b_ramrsp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cs, cs_b;
  logic [16:0] addr;
  logic        rnw;
  logic [1:0]  dsn;
  logic [15:0] din;
  logic        sdram_ack, sdram_dst, sdram_rdy;
  logic [15:0] sdram_data;

  logic [15:0] dout, dout_b;
  logic        ok, ok_b;
  logic        sdram_req, sdram_req_b;
  logic [16:0] sdram_addr, sdram_addr_b;
  logic        sdram_we, sdram_we_b;
  logic [15:0] sdram_din, sdram_din_b;
  logic [1:0]  sdram_wrmask, sdram_wrmask_b;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  jts16b_ramrsp #(.AW(17), .OFFSET(0), .CACHE_EN(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .cs(cs), .addr(addr), .rnw(rnw), .dsn(dsn), .din(din),
    .dout(dout), .ok(ok), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_addr(sdram_addr), .sdram_we(sdram_we), .sdram_din(sdram_din),
    .sdram_wrmask(sdram_wrmask), .sdram_dst(sdram_dst), .sdram_data(sdram_data),
    .sdram_rdy(sdram_rdy)
  );

  jts16b_ramrsp #(.AW(17), .OFFSET(32'h1FFFF), .CACHE_EN(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .cs(cs_b), .addr(addr), .rnw(rnw), .dsn(dsn), .din(din),
    .dout(dout_b), .ok(ok_b), .sdram_req(sdram_req_b), .sdram_ack(sdram_ack),
    .sdram_addr(sdram_addr_b), .sdram_we(sdram_we_b), .sdram_din(sdram_din_b),
    .sdram_wrmask(sdram_wrmask_b), .sdram_dst(sdram_dst), .sdram_data(sdram_data),
    .sdram_rdy(sdram_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic cpu_start(input bit use_b, input logic [16:0] a, input logic r,
                           input logic [1:0] ds, input logic [15:0] d);
    @(negedge clk);
    addr = a; rnw = r; dsn = ds; din = d;
    if (use_b) cs_b = 1'b1;
    else cs = 1'b1;
  endtask

  task automatic cpu_end();
    @(negedge clk);
    cs = 1'b0; cs_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req(input bit use_b, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((use_b ? sdram_req_b : sdram_req) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Pulses ack/dst/rdy at the given cycle offsets (0 = never); drops cs at drop_at.
  task automatic respond(input int ack_d, input int dst_d, input int rdy_d,
                         input logic [15:0] data, input int drop_at);
    int last;
    last = ack_d;
    if (dst_d > last) last = dst_d;
    if (rdy_d > last) last = rdy_d;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      sdram_ack  = (c == ack_d);
      sdram_dst  = (c == dst_d);
      sdram_rdy  = (c == rdy_d);
      sdram_data = data;
      if (c == drop_at) begin
        cs = 1'b0; cs_b = 1'b0;
      end
    end
    @(negedge clk);
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0; cs = 1'b0; cs_b = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // scoreboard access
  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // tests
  task automatic test_reset();
    rstn = 1'b0; cs = 1'b0; cs_b = 1'b0; addr = '0; rnw = 1'b1; dsn = 2'b11; din = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0; sdram_data = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dout, ok, sdram_req, sdram_we, sdram_addr, sdram_din, sdram_wrmask} !==
        {16'h0, 1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_a: got %h/%b/%b/%b/%h/%h/%b exp 0000/0/0/0/00000/0000/11",
               dout, ok, sdram_req, sdram_we, sdram_addr, sdram_din, sdram_wrmask);
    end
    vectors++;
    if ({dout_b, ok_b, sdram_req_b, sdram_wrmask_b} !== {16'h0, 1'b0, 1'b0, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_b: got %h/%b/%b/%b exp 0000/0/0/11", dout_b, ok_b, sdram_req_b, sdram_wrmask_b);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    int cyc;
    logic [15:0] e;
    cpu_start(1'b0, 17'h0100, 1'b1, 2'b11, 16'h0);
    exp_q.push_back(16'hBEEF);
    wait_req(1'b0, cyc);
    vectors++;
    if (cyc !== 1) begin miscompares++; $display("FAIL miss_req_latency: got %0d exp 1", cyc); end
    vectors++;
    if ({sdram_addr, sdram_we, sdram_wrmask} !== {17'h0100, 1'b0, 2'b11}) begin
      miscompares++;
      $display("FAIL miss_cmd: got %h/%b/%b exp 00100/0/11", sdram_addr, sdram_we, sdram_wrmask);
    end
    respond(2, 5, 6, 16'hBEEF, 0);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL miss_ok: got %b exp 1", ok); end
    e = pop_exp();
    vectors++;
    if (dout !== e) begin miscompares++; $display("FAIL miss_dout: got %h exp %h", dout, e); end
    @(negedge clk); @(negedge clk);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL ok_held: got %b exp 1", ok); end
    cpu_end();
    vectors++;
    if (ok !== 1'b0) begin miscompares++; $display("FAIL ok_drop: got %b exp 0", ok); end
  endtask

  task automatic test_read_hit();
    logic [15:0] e;
    cpu_start(1'b0, 17'h0100, 1'b1, 2'b11, 16'h0);
    exp_q.push_back(16'hBEEF);
    @(negedge clk);
    e = pop_exp();
    vectors++;
    if ({ok, sdram_req, dout} !== {1'b1, 1'b0, e}) begin
      miscompares++;
      $display("FAIL hit: got ok=%b req=%b dout=%h exp ok=1 req=0 dout=%h", ok, sdram_req, dout, e);
    end
    cpu_end();
  endtask

  task automatic test_write_merge();
    int cyc;
    logic [15:0] e;
    cpu_start(1'b0, 17'h0100, 1'b0, 2'b01, 16'h12AB);
    wait_req(1'b0, cyc);
    vectors++;
    if ({cyc == 1, sdram_addr, sdram_we, sdram_wrmask, sdram_din} !== {1'b1, 17'h0100, 1'b1, 2'b01, 16'h12AB}) begin
      miscompares++;
      $display("FAIL wr_cmd: got cyc=%0d %h/%b/%b/%h exp cyc=1 00100/1/01/12ab",
               cyc, sdram_addr, sdram_we, sdram_wrmask, sdram_din);
    end
    respond(1, 0, 3, 16'h0, 0);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL wr_ok: got %b exp 1", ok); end
    cpu_end();
    // dsn=11 write completes locally and must not disturb the cached word
    cpu_start(1'b0, 17'h0100, 1'b0, 2'b11, 16'hFFFF);
    @(negedge clk);
    vectors++;
    if ({ok, sdram_req} !== 2'b10) begin
      miscompares++;
      $display("FAIL wr_noop: got ok=%b req=%b exp ok=1 req=0", ok, sdram_req);
    end
    cpu_end();
    cpu_start(1'b0, 17'h0100, 1'b1, 2'b11, 16'h0);
    exp_q.push_back(16'h12EF);
    @(negedge clk);
    e = pop_exp();
    vectors++;
    if ({ok, sdram_req, dout} !== {1'b1, 1'b0, e}) begin
      miscompares++;
      $display("FAIL merge_hit: got ok=%b req=%b dout=%h exp ok=1 req=0 dout=%h", ok, sdram_req, dout, e);
    end
    cpu_end();
  endtask

  task automatic test_ack_rdy_same();
    int cyc;
    logic [15:0] e;
    cpu_start(1'b0, 17'h0100, 1'b0, 2'b10, 16'h0034);
    wait_req(1'b0, cyc);
    respond(2, 0, 2, 16'h0, 0);
    vectors++;
    if ({cyc == 1, ok, sdram_req} !== 3'b110) begin
      miscompares++;
      $display("FAIL ack_rdy_same: got cyc=%0d ok=%b req=%b exp cyc=1 ok=1 req=0", cyc, ok, sdram_req);
    end
    cpu_end();
    cpu_start(1'b0, 17'h0100, 1'b1, 2'b11, 16'h0);
    exp_q.push_back(16'h1234);
    @(negedge clk);
    e = pop_exp();
    vectors++;
    if ({ok, dout} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL ack_rdy_hit: got ok=%b dout=%h exp ok=1 dout=%h", ok, dout, e);
    end
    cpu_end();
  endtask

  task automatic test_abort_write();
    logic [16:0] wa[2];
    logic [1:0]  wds[2];
    logic [15:0] wd[2];
    logic [15:0] hit_val[2];
    int cyc;
    logic [15:0] e;
    wa[0] = 17'h0200; wds[0] = 2'b00; wd[0] = 16'h5678; hit_val[0] = 16'h1234;
    wa[1] = 17'h0100; wds[1] = 2'b10; wd[1] = 16'hAA99; hit_val[1] = 16'h1299;
    for (int i = 0; i < 2; i++) begin
      cpu_start(1'b0, wa[i], 1'b0, wds[i], wd[i]);
      wait_req(1'b0, cyc);
      respond(1, 0, 4, 16'h0, 2);
      vectors++;
      if ({cyc == 1, ok, sdram_req} !== 3'b100) begin
        miscompares++;
        $display("FAIL abort_ok_%0d: got cyc=%0d ok=%b req=%b exp cyc=1 ok=0 req=0", i, cyc, ok, sdram_req);
      end
      @(negedge clk);
      vectors++;
      if (ok !== 1'b0) begin miscompares++; $display("FAIL abort_idle_%0d: got ok=%b exp 0", i, ok); end
      cpu_start(1'b0, 17'h0100, 1'b1, 2'b11, 16'h0);
      exp_q.push_back(hit_val[i]);
      @(negedge clk);
      e = pop_exp();
      vectors++;
      if ({ok, sdram_req, dout} !== {1'b1, 1'b0, e}) begin
        miscompares++;
        $display("FAIL abort_hit_%0d: got ok=%b req=%b dout=%h exp ok=1 req=0 dout=%h", i, ok, sdram_req, dout, e);
      end
      cpu_end();
    end
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    logic [15:0] e;
    cpu_start(1'b0, 17'h0400, 1'b0, 2'b00, 16'h7777);
    wait_req(1'b0, cyc);
    respond(1, 0, 0, 16'h0, 0);
    rstn = 1'b0; cs = 1'b0;
    #1;
    vectors++;
    if ({dout, ok, sdram_req, sdram_we, sdram_addr, sdram_din, sdram_wrmask} !==
        {16'h0, 1'b0, 1'b0, 1'b0, 17'h0, 16'h0, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_wait: got %h/%b/%b/%b/%h/%h/%b exp 0000/0/0/0/00000/0000/11",
               dout, ok, sdram_req, sdram_we, sdram_addr, sdram_din, sdram_wrmask);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    cpu_start(1'b0, 17'h0100, 1'b1, 2'b11, 16'h0);
    exp_q.push_back(16'hA5A5);
    wait_req(1'b0, cyc);
    vectors++;
    if (cyc !== 1) begin miscompares++; $display("FAIL post_reset_miss: got %0d exp 1", cyc); end
    respond(1, 2, 3, 16'hA5A5, 0);
    e = pop_exp();
    vectors++;
    if ({ok, dout} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL post_reset_read: got ok=%b dout=%h exp ok=1 dout=%h", ok, dout, e);
    end
    cpu_end();
  endtask

  task automatic test_offset_nocache();
    logic [15:0] rd[2];
    int cyc;
    logic [15:0] e;
    rd[0] = 16'h3C3C; rd[1] = 16'h4D4D;
    for (int i = 0; i < 2; i++) begin
      cpu_start(1'b1, 17'h00002, 1'b1, 2'b11, 16'h0);
      exp_q.push_back(rd[i]);
      wait_req(1'b1, cyc);
      vectors++;
      if ({cyc == 1, sdram_addr_b, sdram_req} !== {1'b1, 17'h00001, 1'b0}) begin
        miscompares++;
        $display("FAIL offset_addr_%0d: got cyc=%0d addr=%h reqA=%b exp cyc=1 addr=00001 reqA=0",
                 i, cyc, sdram_addr_b, sdram_req);
      end
      respond(1, 2, 3, rd[i], 0);
      e = pop_exp();
      vectors++;
      if ({ok_b, dout_b} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL nocache_read_%0d: got ok=%b dout=%h exp ok=1 dout=%h", i, ok_b, dout_b, e);
      end
      cpu_end();
    end
  endtask

  task automatic test_random();
    logic [15:0] mem[4];
    logic        m_valid;
    logic [16:0] m_tag;
    logic [16:0] a;
    logic        r;
    logic [1:0]  ds;
    logic [15:0] d;
    int idx, cyc, ack_d;
    logic [15:0] e;
    pulse_reset();
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    m_valid = 1'b0; m_tag = '0;
    for (int n = 0; n < 16; n++) begin
      idx = $urandom_range(0, 3);
      a = 17'h0100 + 17'(idx);
      r = 1'($urandom_range(0, 1));
      ds = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      cpu_start(1'b0, a, r, ds, d);
      if (r) begin
        exp_q.push_back(mem[idx]);
        if (m_valid && m_tag == a) begin
          @(negedge clk);
          vectors++;
          if ({ok, sdram_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL rnd_hit_%0d: got ok=%b req=%b exp ok=1 req=0", n, ok, sdram_req);
          end
        end else begin
          wait_req(1'b0, cyc);
          ack_d = $urandom_range(1, 2);
          respond(ack_d, ack_d + 1, ack_d + 2, mem[idx], 0);
          vectors++;
          if ({cyc == 1, ok} !== 2'b11) begin
            miscompares++;
            $display("FAIL rnd_miss_%0d: got cyc=%0d ok=%b exp cyc=1 ok=1", n, cyc, ok);
          end
        end
        e = pop_exp();
        vectors++;
        if (dout !== e) begin miscompares++; $display("FAIL rnd_dout_%0d: got %h exp %h", n, dout, e); end
        m_valid = 1'b1; m_tag = a;
      end else if (ds == 2'b11) begin
        @(negedge clk);
        vectors++;
        if ({ok, sdram_req} !== 2'b10) begin
          miscompares++;
          $display("FAIL rnd_wnoop_%0d: got ok=%b req=%b exp ok=1 req=0", n, ok, sdram_req);
        end
      end else begin
        wait_req(1'b0, cyc);
        vectors++;
        if ({cyc == 1, sdram_addr, sdram_wrmask, sdram_din} !== {1'b1, a, ds, d}) begin
          miscompares++;
          $display("FAIL rnd_wcmd_%0d: got cyc=%0d %h/%b/%h exp cyc=1 %h/%b/%h",
                   n, cyc, sdram_addr, sdram_wrmask, sdram_din, a, ds, d);
        end
        respond(1, 0, 2, 16'h0, 0);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd_wok_%0d: got %b exp 1", n, ok); end
        mem[idx] = {ds[1] ? mem[idx][15:8] : d[15:8], ds[0] ? mem[idx][7:0] : d[7:0]};
      end
      cpu_end();
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_merge();
    test_ack_rdy_same();
    test_abort_write();
    test_reset_in_wait();
    test_offset_nocache();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
